// File: rtl/aes_mode_ctrl.sv
// ECB/CBC block sequencer for a 128-bit AES cipher core: accepts plaintext, chains in CBC,
// drives the core load pulse, guards it with a watchdog and returns ciphertext on a handshake.
module aes_mode_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              cfg_mode,
  input  logic [127:0]      cfg_iv,
  input  logic              cfg_iv_ld,
  input  logic              cfg_abort,
  input  logic              blk_in_valid,
  output logic              blk_in_ready,
  input  logic [127:0]      blk_in_data,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
  output logic [127:0]      blk_out_data,
  output logic              aes_ld,
  output logic [127:0]      aes_text_in,
  input  logic              aes_done,
  input  logic [127:0]      aes_text_out,
  output logic [CNT_W-1:0]  blk_cnt,
  output logic              timeout_err,
  output logic              idle
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC + 1);
  // Loaded with one less than the limit so expiry lands TIMEOUT_CYC cycles after aes_ld.
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BUSY,
    ST_OUTP,
    ST_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [127:0]       chain_q, chain_d;
  logic [127:0]       text_q, text_d;
  logic [127:0]       out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               timeout_q, timeout_d;

  logic               in_ready;
  logic               wdog_expire;
  logic [127:0]       chain_sel;

  assign in_ready    = (state_q == ST_IDLE) && !out_valid_q;
  assign wdog_expire = (wdog_q == '0) || (wdog_q == WD_W'(1));
  // An IV load in the same cycle as a handshake must chain the accepted block with the new IV.
  assign chain_sel   = cfg_iv_ld ? cfg_iv : chain_q;

  always_comb begin
    // NOTE: every next-state value and output gets a default before the case, so no path infers a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    chain_d     = chain_q;
    text_d      = text_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    aes_ld      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_iv_ld) begin
          chain_d   = cfg_iv;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
        if (blk_in_valid && in_ready) begin
          mode_d  = cfg_mode;
          text_d  = cfg_mode ? (blk_in_data ^ chain_sel) : blk_in_data;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        wdog_d = WD_LOAD;
        if (cfg_abort) begin
          state_d = ST_DRAIN;
        end else begin
          aes_ld  = 1'b1;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        wdog_d = wdog_q - WD_W'(1);
        if (cfg_abort) begin
          // A result arriving with the abort is simply discarded; nothing is left to drain.
          state_d = aes_done ? ST_IDLE : ST_DRAIN;
        end else if (aes_done) begin
          out_data_d  = aes_text_out;
          out_valid_d = 1'b1;
          if (mode_q) chain_d = aes_text_out;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = ST_OUTP;
        end else if (wdog_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_OUTP: begin
        if (cfg_abort || blk_out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        // The block was abandoned on purpose, so expiry here ends the drain without flagging an error.
        wdog_d = wdog_q - WD_W'(1);
        if (aes_done || wdog_expire) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    // NOTE: registers use non-blocking assignments so every update sees the pre-edge values.
    if (!rst_n) begin
      // NOTE: the wide data registers are reset as well, so every output is a known zero after reset.
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      chain_q     <= '0;
      text_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      chain_q     <= chain_d;
      text_q      <= text_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
    end
  end

  // Ready is held low while reset is asserted; it rises once the controller is out of reset.
  assign blk_in_ready  = rst_n && in_ready;
  assign blk_out_valid = out_valid_q;
  assign blk_out_data  = out_data_q;
  assign aes_text_in   = text_q;
  assign blk_cnt       = cnt_q;
  assign timeout_err   = timeout_q;
  assign idle          = (state_q == ST_IDLE) && !out_valid_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Self-checking bench for aes_mode_ctrl: a behavioural AES-128 core stub plus a mode/chain/count
// reference model, directed known-answer and corner-case steps, then randomized blocks.
module tb_aes_mode_ctrl;

  localparam int unsigned TIMEOUT_CYC = 20;
  localparam int unsigned CNT_W       = 4;
  localparam int          CNT_MOD     = 1 << CNT_W;

  logic             mclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_mode = 1'b0;
  logic [127:0]     cfg_iv = '0;
  logic             cfg_iv_ld = 1'b0;
  logic             cfg_abort = 1'b0;
  logic             blk_in_valid = 1'b0;
  logic             blk_in_ready;
  logic [127:0]     blk_in_data = '0;
  logic             blk_out_valid;
  logic             blk_out_ready = 1'b0;
  logic [127:0]     blk_out_data;
  logic             aes_ld;
  logic [127:0]     aes_text_in;
  logic             aes_done = 1'b0;
  logic [127:0]     aes_text_out = '0;
  logic [CNT_W-1:0] blk_cnt;
  logic             timeout_err;
  logic             idle;

  int checks   = 0;
  int failures = 0;

  aes_mode_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .mclk         (mclk),
    .rst_n        (rst_n),
    .cfg_mode     (cfg_mode),
    .cfg_iv       (cfg_iv),
    .cfg_iv_ld    (cfg_iv_ld),
    .cfg_abort    (cfg_abort),
    .blk_in_valid (blk_in_valid),
    .blk_in_ready (blk_in_ready),
    .blk_in_data  (blk_in_data),
    .blk_out_valid(blk_out_valid),
    .blk_out_ready(blk_out_ready),
    .blk_out_data (blk_out_data),
    .aes_ld       (aes_ld),
    .aes_text_in  (aes_text_in),
    .aes_done     (aes_done),
    .aes_text_out (aes_text_out),
    .blk_cnt      (blk_cnt),
    .timeout_err  (timeout_err),
    .idle         (idle)
  );

  always #5 mclk = ~mclk;

  // ---------------- AES-128 encryption (FIPS-197), byte 0 = bits [127:120] ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin   // x^254 is the field inverse (0 maps to 0)
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   w [4];
    logic [7:0]   rc = 8'h01;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      w[0] = sbox(k[13]) ^ rc;
      w[1] = sbox(k[14]);
      w[2] = sbox(k[15]);
      w[3] = sbox(k[12]);
      for (int i = 0; i < 4; i++)  k[i] = k[i] ^ w[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- Core stub ----------------
  logic [127:0] key = '0;
  bit           stub_hang = 1'b0;
  bit           spur_done = 1'b0;
  int           stub_lat = 4;
  int           remain = 0;
  logic [127:0] cap = '0;
  int           ld_pulses = 0;
  int           hold_err = 0;

  always @(posedge mclk) begin
    aes_done <= 1'b0;
    if (!rst_n) begin
      remain <= 0;
    end else if (aes_ld) begin
      ld_pulses <= ld_pulses + 1;
      cap       <= aes_text_in;
      remain    <= stub_hang ? -1 : stub_lat;
    end else if (remain == 1) begin
      remain       <= 0;
      aes_done     <= 1'b1;
      aes_text_out <= aes_enc(key, cap);
      if (aes_text_in !== cap) hold_err <= hold_err + 1;
    end else if (remain > 1) begin
      remain <= remain - 1;
    end else if (spur_done) begin
      aes_done     <= 1'b1;
      aes_text_out <= {4{32'hdeadbeef}};
    end
  end

  // ---------------- Reference model state ----------------
  logic [127:0] m_chain = '0;
  int           m_cnt = 0;
  bit           m_err = 1'b0;
  int           m_lds = 0;
  logic         pend_mode;
  logic [127:0] pend_text;
  logic [127:0] pend_ct;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic iv_load(input logic [127:0] iv);
    cfg_iv    = iv;
    cfg_iv_ld = 1'b1;
    step();
    cfg_iv_ld = 1'b0;
    m_chain = iv;
    m_cnt   = 0;
    m_err   = 1'b0;
    check("iv_cnt_clear", blk_cnt, 0);
    check("iv_err_clear", timeout_err, 0);
  endtask

  // Returns in the cycle where aes_ld is expected high.
  task automatic send(input logic [127:0] pt, input logic mode);
    int n = 0;
    blk_in_data  = pt;
    cfg_mode     = mode;
    blk_in_valid = 1'b1;
    #1;
    while (blk_in_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check("in_ready", blk_in_ready, 1);
    pend_mode = mode;
    pend_text = mode ? (pt ^ m_chain) : pt;
    pend_ct   = aes_enc(key, pend_text);
    check("ld_before_accept", aes_ld, 0);
    step();
    blk_in_valid = 1'b0;
    cfg_iv_ld    = 1'b0;
    cfg_mode     = ~mode;
    blk_in_data  = rand128();
    #1;
    m_lds++;
    check("ld_pulse", aes_ld, 1);
    check("text_in", aes_text_in, pend_text);
  endtask

  task automatic finish(input int hold, input bit push, input bit abort_out,
                        output logic [127:0] got);
    int n = 0;
    int ld0;
    while (aes_done !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check("done_seen", aes_done, 1);
    check("valid_before_done", blk_out_valid, 0);
    step();
    check("valid_after_done", blk_out_valid, 1);
    if (pend_mode) m_chain = pend_ct;
    m_cnt = (m_cnt + 1) % CNT_MOD;
    check("blk_cnt", blk_cnt, m_cnt);
    check("timeout_err", timeout_err, m_err);
    ld0 = ld_pulses;
    blk_in_valid = push;
    #1;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", blk_out_valid, 1);
      check("hold_data", blk_out_data, pend_ct);
      check("hold_in_ready", blk_in_ready, 0);
      step();
    end
    blk_in_valid = 1'b0;
    check("no_extra_ld", ld_pulses, ld0);
    check("out_data", blk_out_data, pend_ct);
    got = blk_out_data;
    if (abort_out) cfg_abort = 1'b1;
    else           blk_out_ready = 1'b1;
    step();
    cfg_abort     = 1'b0;
    blk_out_ready = 1'b0;
    #1;
    check("valid_dropped", blk_out_valid, 0);
    check("idle_after", idle, 1);
  endtask

  task automatic run_block(input logic [127:0] pt, input logic mode, input int lat,
                           input int hold, output logic [127:0] got);
    stub_lat = lat;
    send(pt, mode);
    finish(hold, hold > 0, 1'b0, got);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [127:0] got;

    // Reset state
    repeat (3) step();
    check("rst_idle", idle, 1);
    check("rst_in_ready", blk_in_ready, 0);
    check("rst_out_valid", blk_out_valid, 0);
    check("rst_out_data", blk_out_data, 0);
    check("rst_aes_ld", aes_ld, 0);
    check("rst_text_in", aes_text_in, 0);
    check("rst_cnt", blk_cnt, 0);
    check("rst_err", timeout_err, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", blk_in_ready, 1);

    // ECB known answer
    key = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load('0);
    run_block(128'h00112233445566778899aabbccddeeff, 1'b0, 5, 0, got);
    check("kat_ecb", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("kat_ecb_cnt", blk_cnt, 1);

    // CBC known answer, second block under 20 cycles of backpressure with a pending input
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv_load(128'h000102030405060708090a0b0c0d0e0f);
    run_block(128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 7, 0, got);
    check("kat_cbc1", got, 128'h7649abac8119b246cee98e9b12e9197d);
    run_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 3, 20, got);
    check("kat_cbc2", got, 128'h5086cb9b507219ee95db113a917678b2);

    // IV load while busy is ignored
    stub_lat = 8;
    send(rand128(), 1'b1);
    step();
    cfg_iv    = rand128();
    cfg_iv_ld = 1'b1;
    step();
    cfg_iv_ld = 1'b0;
    finish(1, 1'b0, 1'b0, got);

    // IV load coinciding with acceptance: the block uses the new IV
    cfg_iv    = rand128();
    cfg_iv_ld = 1'b1;
    m_chain   = cfg_iv;
    m_cnt     = 0;
    m_err     = 1'b0;
    stub_lat  = 4;
    send(rand128(), 1'b1);
    finish(0, 1'b0, 1'b0, got);

    // Watchdog: core never finishes, CBC chain and count stay put
    stub_hang = 1'b1;
    send(rand128(), 1'b1);
    repeat (TIMEOUT_CYC - 1) step();
    check("to_not_early", timeout_err, 0);
    check("to_busy_not_idle", idle, 0);
    step();
    check("to_set", timeout_err, 1);
    check("to_idle", idle, 1);
    check("to_no_valid", blk_out_valid, 0);
    check("to_cnt", blk_cnt, m_cnt);
    stub_hang = 1'b0;
    m_err = 1'b1;
    run_block(rand128(), 1'b1, 6, 0, got);
    iv_load(rand128());

    // Abort 3 cycles after aes_ld: no output, wait for the core before accepting again
    stub_lat = 10;
    send(rand128(), 1'b1);
    repeat (3) step();
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    #1;
    check("abort_in_ready", blk_in_ready, 0);
    check("abort_no_valid", blk_out_valid, 0);
    for (int n = 0; n < 64 && aes_done !== 1'b1; n++) step();
    check("abort_done_seen", aes_done, 1);
    check("abort_drain_ready", blk_in_ready, 0);
    step();
    check("abort_idle_ready", blk_in_ready, 1);
    check("abort_drain_no_valid", blk_out_valid, 0);
    check("abort_cnt", blk_cnt, m_cnt);
    run_block(rand128(), 1'b1, 2, 0, got);

    // Abort while output is pending: result dropped, chain and count already advanced
    stub_lat = 3;
    send(rand128(), 1'b1);
    finish(2, 1'b0, 1'b1, got);
    run_block(rand128(), 1'b1, 4, 0, got);

    // Stray aes_done in IDLE is ignored
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    check("spur_idle", idle, 1);
    check("spur_no_valid", blk_out_valid, 0);
    check("spur_cnt", blk_cnt, m_cnt);

    // Block counter wraps from all-ones to zero
    iv_load(rand128());
    for (int b = 0; b < CNT_MOD - 1; b++)
      run_block(rand128(), 1'($urandom_range(0, 1)), $urandom_range(1, 4), 0, got);
    check("cnt_all_ones", blk_cnt, 4'hF);
    run_block(rand128(), 1'b0, 2, 0, got);
    check("cnt_wrapped", blk_cnt, 0);

    // Randomized blocks
    for (int b = 0; b < 24; b++) begin
      if ($urandom_range(0, 5) == 0) iv_load(rand128());
      stub_lat = $urandom_range(1, 12);
      send(rand128(), 1'($urandom_range(0, 1)));
      finish($urandom_range(0, 3), 1'b0, 1'b0, got);
    end

    // Reset mid-operation
    stub_lat = 8;
    send(rand128(), 1'b1);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    check("midrst_idle", idle, 1);
    check("midrst_cnt", blk_cnt, 0);
    check("midrst_no_valid", blk_out_valid, 0);
    check("midrst_text", aes_text_in, 0);
    rst_n = 1'b1;
    m_chain = '0;
    m_cnt   = 0;
    m_err   = 1'b0;
    step();
    check("midrst_ready", blk_in_ready, 1);
    run_block(rand128(), 1'b1, 5, 0, got);

    step();
    check("text_held_to_done", hold_err, 0);
    check("ld_pulse_total", ld_pulses, m_lds);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
